// File: rtl/enc_ntom_if.sv
// Handshake bundle for enc_ntom: capture enable and request lines in, granted index out.
// The master side drives requests and ready; the slave side (the encoder) drives Dout/valid/pending.
interface enc_ntom_if #(
    parameter int N = 8,
    parameter int M = 3
);
    logic         _en;
    logic [N-1:0] Din;
    logic         ready;
    logic [M-1:0] Dout;
    logic         valid;
    logic [N-1:0] pending;

    modport master (
        output _en, Din, ready,
        input  Dout, valid, pending
    );

    modport slave (
        input  _en, Din, ready,
        output Dout, valid, pending
    );
endinterface

// File: rtl/enc_ntom.sv
// Registered N-to-M priority encoder with sticky pending requests and a valid/ready grant.
// Define ROUND_ROBIN_EN to rotate priority from the last accepted index instead of fixed MSB-first.
module enc_ntom #(
    parameter int N = 8,
    parameter int M = 3
) (
    input  logic      clk,
    input  logic      rst,
    enc_ntom_if.slave bus
);

    if (N < 2 || N > (2 ** M)) begin : gen_bad_params
        $error("enc_ntom: N must satisfy 2 <= N <= 2**M");
    end

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [N-1:0] ONE_HOT_BASE = {{(N-1){1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic [M-1:0] dout_q, dout_d;
    logic [M-1:0] sel;
    logic [N-1:0] clr;
    logic         accept;

    assign accept = (state_q == HOLD) && bus.ready;

`ifdef ROUND_ROBIN_EN
    // startQ is where the next search begins, i.e. one below the last accepted index.
    logic [M-1:0] start_q, start_d;

    always_comb begin
        sel = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (pending_q[(int'(start_q) + N - k) % N]) begin
                sel = M'((int'(start_q) + N - k) % N);
            end
        end
    end

    always_comb begin
        start_d = start_q;
        if (accept) begin
            start_d = (dout_q == '0) ? M'(N - 1) : dout_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= M'(N - 1);
        end else begin
            start_q <= start_d;
        end
    end
`else
    always_comb begin
        sel = '0;
        for (int k = 0; k < N; k++) begin
            if (pending_q[k]) begin
                sel = M'(k);
            end
        end
    end
`endif

    // A fresh capture of the bit being cleared re-arms it, so set wins over clear.
    always_comb begin
        clr       = accept ? (ONE_HOT_BASE << dout_q) : '0;
        pending_d = (pending_q & ~clr) | (bus._en ? '0 : bus.Din);
        state_d   = state_q;
        dout_d    = dout_q;
        case (state_q)
            IDLE: begin
                if (pending_q != '0) begin
                    dout_d  = sel;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            dout_q    <= dout_d;
        end
    end

    assign bus.Dout    = dout_q;
    assign bus.valid   = (state_q == HOLD);
    assign bus.pending = pending_q;

endmodule

// File: tb/tb_enc_ntom.sv
// Directed self-checking bench for enc_ntom (N=8, M=3); expectations adapt to ROUND_ROBIN_EN.
module tb_enc_ntom;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    enc_ntom_if #(.N(8), .M(3)) bus ();

    enc_ntom #(.N(8), .M(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus._en = 1'b0; bus.Din = 8'hFF; bus.ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.pending !== 8'h00 || bus.valid !== 1'b0 || bus.Dout !== 3'd0) begin
                errors++;
                $display("[TB] FAIL reset_hold got pending=%h valid=%b Dout=%0d want 00/0/0", bus.pending, bus.valid, bus.Dout);
            end
        end
        rst = 1'b0; bus.Din = 8'h00;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.pending !== 8'h00 || bus.valid !== 1'b0 || bus.Dout !== 3'd0) begin
                errors++;
                $display("[TB] FAIL reset_release got pending=%h valid=%b Dout=%0d want 00/0/0", bus.pending, bus.valid, bus.Dout);
            end
        end
    endtask

    task automatic test_single();
        bus._en = 1'b0; bus.Din = 8'h20; bus.ready = 1'b1;
        tick();
        bus.Din = 8'h00;
        checks++;
        if (bus.pending !== 8'h20 || bus.valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_capture got pending=%h valid=%b want 20/0", bus.pending, bus.valid);
        end
        tick();
        checks++;
        if (bus.valid !== 1'b1 || bus.Dout !== 3'd5) begin
            errors++;
            $display("[TB] FAIL single_grant got valid=%b Dout=%0d want 1/5", bus.valid, bus.Dout);
        end
        tick();
        checks++;
        if (bus.pending !== 8'h00 || bus.valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_accept got pending=%h valid=%b want 00/0", bus.pending, bus.valid);
        end
    endtask

    task automatic test_multi();
        logic [2:0] expIdx [3];
        logic [7:0] expPend [3];
        expIdx  = '{3'd7, 3'd4, 3'd0};
        expPend = '{8'h11, 8'h01, 8'h00};
        bus._en = 1'b0; bus.Din = 8'h91; bus.ready = 1'b1;
        tick();
        bus.Din = 8'h00;
        for (int g = 0; g < 3; g++) begin
            tick();
            checks++;
            if (bus.valid !== 1'b1 || bus.Dout !== expIdx[g]) begin
                errors++;
                $display("[TB] FAIL multi_grant%0d got valid=%b Dout=%0d want 1/%0d", g, bus.valid, bus.Dout, expIdx[g]);
            end
            tick();
            checks++;
            if (bus.valid !== 1'b0 || bus.pending !== expPend[g]) begin
                errors++;
                $display("[TB] FAIL multi_drain%0d got valid=%b pending=%h want 0/%h", g, bus.valid, bus.pending, expPend[g]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bus._en = 1'b0; bus.Din = 8'h80; bus.ready = 1'b0;
        tick();
        bus.Din = 8'h00;
        tick();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.valid !== 1'b1 || bus.Dout !== 3'd7) begin
                errors++;
                $display("[TB] FAIL backpressure_hold%0d got valid=%b Dout=%0d want 1/7", i, bus.valid, bus.Dout);
            end
            bus.Din = (i == 4) ? 8'h02 : 8'h00;
            tick();
        end
        bus.Din = 8'h00;
        checks++;
        if (bus.pending !== 8'h82) begin
            errors++;
            $display("[TB] FAIL backpressure_merge got pending=%h want 82", bus.pending);
        end
        bus.ready = 1'b1;
        tick();
        checks++;
        if (bus.valid !== 1'b0 || bus.pending !== 8'h02) begin
            errors++;
            $display("[TB] FAIL backpressure_accept got valid=%b pending=%h want 0/02", bus.valid, bus.pending);
        end
        tick();
        checks++;
        if (bus.valid !== 1'b1 || bus.Dout !== 3'd1) begin
            errors++;
            $display("[TB] FAIL backpressure_next got valid=%b Dout=%0d want 1/1", bus.valid, bus.Dout);
        end
        tick();
        checks++;
        if (bus.valid !== 1'b0 || bus.pending !== 8'h00) begin
            errors++;
            $display("[TB] FAIL backpressure_empty got valid=%b pending=%h want 0/00", bus.valid, bus.pending);
        end
    endtask

    task automatic test_enable();
        bus._en = 1'b1; bus.Din = 8'hFF; bus.ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.pending !== 8'h00 || bus.valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL enable_mask%0d got pending=%h valid=%b want 00/0", i, bus.pending, bus.valid);
            end
        end
        bus._en = 1'b0; bus.Din = 8'h04; bus.ready = 1'b0;
        tick();
        bus._en = 1'b1; bus.Din = 8'hFF;
        checks++;
        if (bus.pending !== 8'h04) begin
            errors++;
            $display("[TB] FAIL enable_prepend got pending=%h want 04", bus.pending);
        end
        tick();
        checks++;
        if (bus.valid !== 1'b1 || bus.Dout !== 3'd2) begin
            errors++;
            $display("[TB] FAIL enable_drain got valid=%b Dout=%0d want 1/2", bus.valid, bus.Dout);
        end
        bus.ready = 1'b1;
        tick();
        checks++;
        if (bus.valid !== 1'b0 || bus.pending !== 8'h00) begin
            errors++;
            $display("[TB] FAIL enable_empty got valid=%b pending=%h want 0/00", bus.valid, bus.pending);
        end
    endtask

    task automatic test_reset_mid_hold();
        bus._en = 1'b0; bus.Din = 8'h11; bus.ready = 1'b0;
        tick();
        bus.Din = 8'h00;
        tick();
        checks++;
        if (bus.valid !== 1'b1 || bus.Dout !== 3'd4) begin
            errors++;
            $display("[TB] FAIL midhold_grant got valid=%b Dout=%0d want 1/4", bus.valid, bus.Dout);
        end
        rst = 1'b1; bus.Din = 8'hFF;
        tick();
        rst = 1'b0; bus.Din = 8'h00;
        checks++;
        if (bus.valid !== 1'b0 || bus.pending !== 8'h00 || bus.Dout !== 3'd0) begin
            errors++;
            $display("[TB] FAIL midhold_reset got valid=%b pending=%h Dout=%0d want 0/00/0", bus.valid, bus.pending, bus.Dout);
        end
    endtask

    task automatic test_priority();
        logic [2:0] expIdx [4];
`ifdef ROUND_ROBIN_EN
        expIdx = '{3'd7, 3'd0, 3'd7, 3'd0};
`else
        expIdx = '{3'd7, 3'd7, 3'd7, 3'd7};
`endif
        rst = 1'b1; bus._en = 1'b1; bus.Din = 8'h00; bus.ready = 1'b0;
        tick();
        rst = 1'b0; bus._en = 1'b0; bus.Din = 8'h81; bus.ready = 1'b1;
        tick();
        for (int g = 0; g < 4; g++) begin
            tick();
            checks++;
            if (bus.valid !== 1'b1 || bus.Dout !== expIdx[g]) begin
                errors++;
                $display("[TB] FAIL priority_grant%0d got valid=%b Dout=%0d want 1/%0d", g, bus.valid, bus.Dout, expIdx[g]);
            end
            tick();
            checks++;
            if (bus.valid !== 1'b0 || bus.pending !== 8'h81) begin
                errors++;
                $display("[TB] FAIL priority_rearm%0d got valid=%b pending=%h want 0/81", g, bus.valid, bus.pending);
            end
        end
        bus._en = 1'b1; bus.Din = 8'h00;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; bus._en = 1'b1; bus.Din = 8'h00; bus.ready = 1'b0;
        test_reset();
        test_single();
        test_multi();
        test_back_to_back();
        test_enable();
        test_reset_mid_hold();
        test_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/enc_ntom.md
Name: enc_NtoM

Overview:
Registered N-to-M priority encoder. It is the inverse of the team's M-to-N decoder and keeps the same active-low enable convention.
- Captures request lines into a sticky pending register.
- Presents one encoded index at a time over a valid/ready handshake.
- Clears each request bit only when its index is accepted.
- Sits between one-hot/multi-hot request sources (decoder outputs, buttons, interrupt lines) and a binary-index consumer.

Parameters:
N, 8, number of request lines (N >= 2)
M, 3, encoded index width; N must satisfy N <= 2**M (elaboration error otherwise)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
_en  input  1  active-low capture enable; 0 = sample Din, 1 = ignore Din
Din  input  N  request lines, sampled every edge while _en=0
ready  input  1  consumer accepts Dout when valid=1 and ready=1 at an edge
Dout  output  M  encoded index of granted request
valid  output  1  Dout holds a granted index
pending  output  N  current pending-request register

Behaviour:
- Reset values (rst=1 at an edge): pending=0, Dout=0, valid=0, FSM=IDLE. Din is ignored during reset cycles.
- Pending update each edge: pending_next = (pending & ~clr) | (_en ? 0 : Din).
  - clr is the one-hot of Dout when valid & ready, otherwise 0.
  - If a bit is set and cleared in the same edge, the set wins; the request re-arms.
- _en=1 masks capture only. Already-pending bits still drain normally.
- FSM has two states, IDLE and HOLD.
  - IDLE: if the registered pending != 0, load Dout with the highest-priority set index, set valid=1, and go to HOLD. Otherwise stay, with valid=0 and Dout holding its last value.
  - HOLD: valid=1; Dout and the selected index stay stable regardless of new Din. When ready=1, clear that pending bit, set valid=0, and return to IDLE.
- Fixed priority: MSB first; index N-1 is highest.
- Latency:
  - A Din bit sampled at edge t appears in pending after edge t.
  - valid=1 and Dout are seen after edge t+1 (if FSM is in IDLE).
- Throughput: at most one grant per 2 cycles. An accept at edge k gives valid=0 after k; the earliest next valid=1 is after edge k+1.
- ready while valid=0 has no effect.
- Reset mid-HOLD: the grant is dropped, valid=0 next cycle, and all pending bits are lost.
- Din bits at index >= N do not exist. Dout is never >= N.

Optional Feature:
Macro ROUND_ROBIN_EN.
- Defined: a pointer register holds the last accepted index g (reset value N-1, with the first search as if g=0). The search starts at (g-1) mod N and proceeds downward with wrap to N-1. The pointer updates only on accept.
- Undefined: fixed MSB-first priority as above; no pointer register.

Test Plan:
1. Reset: rst=1 for 2 cycles with _en=0, Din=8'hFF -> pending=0, valid=0, Dout=0 throughout; after release with Din=0, outputs remain 0.
2. Single request: _en=0, Din=8'h20 for one cycle, ready=1 -> pending=8'h20 next edge; valid=1, Dout=5 the following edge; after accept, pending=0, valid=0.
3. Multi-request fixed priority: Din=8'h91 for one cycle, ready held 1 -> grants Dout=7, 4, 0 at cycles t+1, t+3, t+5; pending then 0.
4. Backpressure/merge: one request on bit 7, ready=0 for 10 cycles, Din=8'h02 mid-hold -> Dout=7, valid=1 stable for all 10 cycles, pending=8'h82. After ready=1: grant 1 two cycles later.
5. Enable masking: _en=1, Din=8'hFF for 5 cycles -> pending=0, valid=0. A pre-pending 8'h04 still drains (Dout=2).
6. Priority policy: Din=8'h81 held every cycle, _en=0, ready=1 -> without ROUND_ROBIN_EN grants 7,7,7,...; with ROUND_ROBIN_EN grants 7,0,7,0,....
